pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline control unit for the 5-stage pip_cpu.
- Produces every stall and flush control consumed by the IF/ID, ID/EX and EX/LS pipeline registers and the PC register.
- Detects load-use hazards, holds the pipe for multi-cycle EX ops and outstanding LS memory requests, and issues branch/trap redirects.
- Sits beside the datapath; the pipeline registers are its only stall/flush consumers.

Parameters:
- XLEN, 64, PC/target width.
- MEM_TIMEOUT, 255, max cycles LS may wait for ls_ack before bus_err.
- CNT_W, 32, width of each saturating perf counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_rs1_addr  in  5  ID source reg 1
- id_rs2_addr  in  5  ID source reg 2
- id_rs1_used  in  1  ID inst reads rs1
- id_rs2_used  in  1  ID inst reads rs2
- ex_load_flag  in  1  EX inst is a load
- ex_rd_ena  in  1  EX inst writes rd
- ex_rd_addr  in  5  EX rd
- ex_mc_start  in  1  pulse: multi-cycle op (mul/div) begins in EX
- ex_mc_done  in  1  pulse: multi-cycle result ready
- ex_br_taken  in  1  EX resolved taken branch/jump
- ex_br_target  in  XLEN  branch target
- ls_req  in  1  LS memory request active
- ls_ack  in  1  memory response
- ls_trap  in  1  exception/ecall/mret at LS
- ls_trap_target  in  XLEN  trap vector/return PC
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  clear IF/ID
- idex_stall  out  1  hold ID/EX
- idex_flush  out  1  clear ID/EX (bubble)
- exls_stall  out  1  hold EX/LS
- exls_flush  out  1  clear EX/LS
- redirect_valid  out  1  PC redirect pulse
- redirect_pc  out  XLEN  redirect target
- bus_err  out  1  one-cycle pulse on memory timeout
- stall_cycles  out  CNT_W  cycles with pc_stall high
- flush_count  out  CNT_W  redirect events

Behaviour:
- Reset: FSM=IDLE, timeout counter=0, redirect_valid=0, redirect_pc=0, bus_err=0, both counters=0.
  - All combinational stall/flush outputs=0 while rst is high.
- FSM states:
  - IDLE -> MC_BUSY on ex_mc_start (when no mem wait and no trap).
  - IDLE -> MEM_WAIT on ls_req & !ls_ack.
  - MC_BUSY -> IDLE on ex_mc_done or ls_trap.
  - MEM_WAIT -> IDLE on ls_ack, ls_trap, or timeout.
- Timeout counter:
  - Increments each MEM_WAIT cycle; clears on leaving MEM_WAIT.
  - Reaching MEM_TIMEOUT-1 forces MEM_WAIT -> IDLE and pulses bus_err the next cycle.
- Stall/flush decode is combinational from the current state and inputs. Priority, highest first:
  1. ls_trap:
     - ifid_flush = idex_flush = exls_flush = 1; all stalls 0.
     - Redirect to ls_trap_target.
     - Overrides mem wait and MC_BUSY.
  2. mem wait (MEM_WAIT, or IDLE with ls_req & !ls_ack):
     - pc_stall = ifid_stall = idex_stall = exls_stall = 1.
  3. multi-cycle (MC_BUSY, or ex_mc_start in IDLE):
     - pc_stall = ifid_stall = idex_stall = 1.
     - exls_flush = 1 (bubble into LS).
  4. ex_br_taken:
     - ifid_flush = idex_flush = 1.
     - Redirect to ex_br_target.
  5. load-use, when ex_load_flag & ex_rd_ena & ex_rd_addr != 0 & ((id_rs1_used & rs1 == rd) | (id_rs2_used & rs2 == rd)):
     - pc_stall = ifid_stall = 1, idex_flush = 1.
     - Exactly one bubble, because the load leaves EX the next cycle.
- Invariant: stall and flush for the same register are never both high. A pipeline register gives stall priority over flush, so the controller guarantees exclusivity itself.
- A branch or load-use arriving while a higher-priority condition is active is not lost: EX is held, so the condition is re-evaluated once the hold releases.
- Redirect timing:
  - redirect_valid/redirect_pc are registered: one-cycle pulse in the cycle after the trap/branch.
  - redirect_pc holds its last value when redirect_valid=0.
- Counters:
  - stall_cycles increments each cycle pc_stall=1.
  - flush_count increments on each trap or taken-branch event.
  - Both saturate at all-ones.
- Reset mid-operation: the next edge returns the FSM to IDLE and clears the counters. The pending ack is ignored.
- ex_mc_done arriving in IDLE: ignored.

Decomposition:
- Shared define file gets:
  - FSM state encodings: IDLE=2'd0, MC_BUSY=2'd1, MEM_WAIT=2'd2.
  - CNT_W default.
  - MEM_TIMEOUT default.
- Reuse the existing XLEN/REGADDR macros.
- One sub-module: pipe_hazard_perf, holding the two saturating counters.

Test Plan:
- Load-use: ex_load_flag=1, ex_rd_addr=5, id_rs2_used=1, id_rs2_addr=5 -> one cycle pc_stall=ifid_stall=idex_flush=1, then all 0. Same with ex_rd_addr=0 -> no stall.
- Branch: ex_br_taken=1, target 0x8000_0040 -> same cycle ifid_flush=idex_flush=1; next cycle redirect_valid=1, redirect_pc=0x8000_0040; flush_count=1.
- Multi-cycle: ex_mc_start at t0, ex_mc_done at t0+33 -> pc/ifid/idex stall and exls_flush high t0..t0+33, released at t0+34; stall_cycles=34.
- Memory wait: ls_req=1, ls_ack at the 4th cycle -> all four stalls high for 4 cycles. Also ls_req with no ack -> after 255 cycles bus_err pulses once and the FSM returns to IDLE.
- Trap during MEM_WAIT plus branch: ls_trap=1, ex_br_taken=1 in the same cycle -> flushes all three registers, all stalls 0, redirect_pc=ls_trap_target (branch ignored).
- Reset mid MC_BUSY: rst pulse -> next cycle all outputs 0 and counters 0; a later ex_mc_done has no effect.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// default widths and limits, and the source-operand match helper.
package pipe_hazard_pkg;

    localparam int XLEN_DEF        = 64;
    localparam int REGADDR_W       = 5;
    localparam int CNT_W_DEF       = 32;
    localparam int MEM_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MC_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    // True when an ID source operand that is actually read matches an EX rd.
    function automatic logic src_hit(input logic used,
                                     input logic [REGADDR_W-1:0] rs,
                                     input logic [REGADDR_W-1:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_hazard_perf.sv
// Saturating performance counters: stalled cycles and redirect events.
module pipe_hazard_perf
    import pipe_hazard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_stall_i,
    input  logic             inc_flush_i,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Next-count: bump on event unless already pinned at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (inc_stall_i && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (inc_flush_i && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // Counter registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/redirect controller for the 5-stage pipeline.
// Conditions are prioritised trap > memory wait > multi-cycle > branch >
// load-use so that no register ever sees stall and flush together.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REGADDR_W-1:0] id_rs1_addr,
    input  logic [REGADDR_W-1:0] id_rs2_addr,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic                 ex_load_flag,
    input  logic                 ex_rd_ena,
    input  logic [REGADDR_W-1:0] ex_rd_addr,
    input  logic                 ex_mc_start,
    input  logic                 ex_mc_done,
    input  logic                 ex_br_taken,
    input  logic [XLEN-1:0]      ex_br_target,
    input  logic                 ls_req,
    input  logic                 ls_ack,
    input  logic                 ls_trap,
    input  logic [XLEN-1:0]      ls_trap_target,
    output logic                 pc_stall,
    output logic                 ifid_stall,
    output logic                 ifid_flush,
    output logic                 idex_stall,
    output logic                 idex_flush,
    output logic                 exls_stall,
    output logic                 exls_flush,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 bus_err,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    hz_state_e        state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             redir_vld_q, redir_vld_d;
    logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
    logic             bus_err_q, bus_err_d;

    logic mem_wait, mc_hold, load_use;

    // Next state, timeout count and registered redirect/bus_err request.
    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        bus_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ls_trap)               state_d = IDLE;
                else if (ls_req && !ls_ack) state_d = MEM_WAIT;
                else if (ex_mc_start)      state_d = MC_BUSY;
            end
            MC_BUSY: begin
                if (ex_mc_done || ls_trap) state_d = IDLE;
            end
            MEM_WAIT: begin
                if (ls_ack || ls_trap) begin
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prioritised stall/flush decode; also selects the redirect source.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exls_stall  = 1'b0;
        exls_flush  = 1'b0;
        redir_vld_d = 1'b0;
        redir_pc_d  = redir_pc_q;

        mem_wait = (state_q == MEM_WAIT) || (state_q == IDLE && ls_req && !ls_ack);
        mc_hold  = (state_q == MC_BUSY)  || (state_q == IDLE && ex_mc_start);
        load_use = ex_load_flag && ex_rd_ena && (ex_rd_addr != '0) &&
                   (src_hit(id_rs1_used, id_rs1_addr, ex_rd_addr) ||
                    src_hit(id_rs2_used, id_rs2_addr, ex_rd_addr));

        if (rst) begin
            redir_vld_d = 1'b0;
        end else if (ls_trap) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exls_flush  = 1'b1;
            redir_vld_d = 1'b1;
            redir_pc_d  = ls_trap_target;
        end else if (mem_wait) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            exls_stall = 1'b1;
        end else if (mc_hold) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            exls_flush = 1'b1;
        end else if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            redir_vld_d = 1'b1;
            redir_pc_d  = ex_br_target;
        end else if (load_use) begin
            // The load moves to LS next cycle, so a single bubble suffices.
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end
    end

    // State, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign redirect_valid = redir_vld_q;
    assign redirect_pc    = redir_pc_q;
    assign bus_err        = bus_err_q;

    pipe_hazard_perf #(.CNT_W(CNT_W)) u_perf (
        .clk            (clk),
        .rst            (rst),
        .inc_stall_i    (pc_stall),
        .inc_flush_i    (redir_vld_d),
        .stall_cycles_o (stall_cycles),
        .flush_count_o  (flush_count)
    );

endmodule
